// File: rtl/dlx_multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the DLX datapath.
// Define SEQ_PERF_CNT_EN to add the retired_cnt/stall_cnt performance counters.
module dlx_multicycle_seq #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             mem_wr,
   input  logic             reg_wr,
   input  logic             mem_to_reg,
   input  logic             branch_z,
   input  logic             branch_nz,
   input  logic             jmp,
   input  logic             jmp_r,
   input  logic             link,
   input  logic             zero,
   output logic             imem_req,
   output logic             ir_load,
   output logic             pc_load,
   output logic [1:0]       pc_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             instr_done,
   output logic             trap,
   output logic [2:0]       state
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
      $error("dlx_multicycle_seq: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
   end

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign taken = jmp | jmp_r | (branch_z & zero) | (branch_nz & ~zero);

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      pc_load    = 1'b0;
      pc_sel     = 2'd0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = 2'd0;
      instr_done = 1'b0;
      trap       = 1'b0;
      state      = state_q;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load = 1'b1;
               pc_load = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == TIMEOUT_LIM) begin
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (taken) begin
               pc_load = 1'b1;
               pc_sel  = jmp_r ? 2'd3 : (jmp ? 2'd2 : 2'd1);
            end
            if (mem_wr | mem_to_reg) begin
               state_d = S_MEM;
            end else if (reg_wr | link) begin
               state_d = S_WB;
            end else begin
               state_d    = S_FETCH;
               instr_done = 1'b1;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = mem_wr;
            if (dmem_ready) begin
               if (mem_to_reg) begin
                  state_d = S_WB;
               end else begin
                  state_d    = S_FETCH;
                  instr_done = 1'b1;
               end
            end else if (wait_q == TIMEOUT_LIM) begin
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            wb_sel     = link ? 2'd2 : (mem_to_reg ? 2'd1 : 2'd0);
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: state_d = S_FETCH;
      endcase

      // Any state change starts a fresh wait window.
      if (state_d != state_q) begin
         wait_d = '0;
      end

      if (reset) begin
         imem_req   = 1'b0;
         ir_load    = 1'b0;
         pc_load    = 1'b0;
         pc_sel     = 2'd0;
         dmem_req   = 1'b0;
         dmem_we    = 1'b0;
         rf_we      = 1'b0;
         wb_sel     = 2'd0;
         instr_done = 1'b0;
         trap       = 1'b0;
         state      = 3'd0;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic stall;

   assign stall = ((state_q == S_FETCH) & ~imem_ready) | ((state_q == S_MEM) & ~dmem_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (instr_done) retired_cnt <= retired_cnt + 1'b1;
         if (stall)      stall_cnt   <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dlx_multicycle_seq.sv
// Directed testbench for dlx_multicycle_seq (MEM_TIMEOUT=4).
module tb_dlx_multicycle_seq;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic imem_ready = 1'b0, dmem_ready = 1'b0;
   logic mem_wr = 1'b0, reg_wr = 1'b0, mem_to_reg = 1'b0;
   logic branch_z = 1'b0, branch_nz = 1'b0, jmp = 1'b0, jmp_r = 1'b0, link = 1'b0, zero = 1'b0;
   logic imem_req, ir_load, pc_load, dmem_req, dmem_we, rf_we, instr_done, trap;
   logic [1:0] pc_sel, wb_sel;
   logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] retired_cnt, stall_cnt;
`endif

   int passed = 0;
   int total  = 0;

   // {imem_req, ir_load, pc_load, pc_sel, dmem_req, dmem_we, rf_we, wb_sel, instr_done, trap, state}
   logic [14:0] obs;
   assign obs = {imem_req, ir_load, pc_load, pc_sel, dmem_req, dmem_we, rf_we, wb_sel,
                 instr_done, trap, state};

   localparam logic [14:0] O_FETCH_OK   = 15'b111_00_000_00_00_000;
   localparam logic [14:0] O_FETCH_WAIT = 15'b100_00_000_00_00_000;
   localparam logic [14:0] O_DECODE     = 15'b000_00_000_00_00_001;
   localparam logic [14:0] O_TRAP       = 15'b000_00_000_00_01_101;

   always #5 clk = ~clk;

   dlx_multicycle_seq #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .mem_wr(mem_wr), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .branch_z(branch_z),
      .branch_nz(branch_nz), .jmp(jmp), .jmp_r(jmp_r), .link(link), .zero(zero),
      .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
      .instr_done(instr_done), .trap(trap), .state(state)
`ifdef SEQ_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      tick();
      tick();
      #2;
      total++;
      if (obs !== 15'd0) $display("FAIL reset_outputs: got %b want %b", obs, 15'd0);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_add();
      logic [14:0] exp [4];
      exp = '{O_FETCH_OK, O_DECODE, 15'b000_00_000_00_00_010, 15'b000_00_001_00_10_100};
      imem_ready = 1'b1; dmem_ready = 1'b1; reg_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL add_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
      reg_wr = 1'b0;
   endtask

   task automatic test_load_wait();
      logic [14:0] exp [8];
      logic        drdy [8];
      exp  = '{O_FETCH_OK, O_DECODE, 15'b000_00_000_00_00_010,
               15'b000_00_100_00_00_011, 15'b000_00_100_00_00_011,
               15'b000_00_100_00_00_011, 15'b000_00_100_00_00_011,
               15'b000_00_001_01_10_100};
      drdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      imem_ready = 1'b1; mem_to_reg = 1'b1; reg_wr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dmem_ready = drdy[i];
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL lw_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
      mem_to_reg = 1'b0; reg_wr = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic test_store();
      logic [14:0] exp [4];
      exp = '{O_FETCH_OK, O_DECODE, 15'b000_00_000_00_00_010, 15'b000_00_110_00_10_011};
      imem_ready = 1'b1; dmem_ready = 1'b1; mem_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL sw_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
      mem_wr = 1'b0;
   endtask

   task automatic test_branch();
      logic [14:0] exp [6];
      exp = '{O_FETCH_OK, O_DECODE, 15'b001_01_000_00_10_010,
              O_FETCH_OK, O_DECODE, 15'b000_00_000_00_10_010};
      imem_ready = 1'b1; branch_z = 1'b1;
      for (int i = 0; i < 6; i++) begin
         zero = (i < 3);
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL beqz_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
      branch_z = 1'b0; zero = 1'b0;
   endtask

   task automatic test_jump();
      logic [14:0] exp [8];
      exp = '{O_FETCH_OK, O_DECODE, 15'b001_10_000_00_00_010, 15'b000_00_001_10_10_100,
              O_FETCH_OK, O_DECODE, 15'b001_11_000_00_00_010, 15'b000_00_001_10_10_100};
      imem_ready = 1'b1; jmp = 1'b1; link = 1'b1; reg_wr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         jmp_r = (i >= 4);
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL jal_jalr_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
      jmp = 1'b0; jmp_r = 1'b0; link = 1'b0; reg_wr = 1'b0;
   endtask

   task automatic test_fetch_limit();
      logic [14:0] exp [7];
      exp = '{O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_OK,
              O_DECODE, 15'b000_00_000_00_10_010};
      for (int i = 0; i < 7; i++) begin
         imem_ready = (i >= 4);
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL fetch_limit_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
`ifdef SEQ_PERF_CNT_EN
      total++;
      if (retired_cnt !== 32'd8) $display("FAIL retired_cnt: got %0d want 8", retired_cnt);
      else passed++;
      total++;
      if (stall_cnt !== 32'd7) $display("FAIL stall_cnt: got %0d want 7", stall_cnt);
      else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      imem_ready = 1'b1; jmp = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #2;
      total++;
      if (obs !== 15'd0) $display("FAIL reset_mid_exec: got %b want %b", obs, 15'd0);
      else passed++;
      tick();
      reset = 1'b0; jmp = 1'b0; imem_ready = 1'b0;
`ifdef SEQ_PERF_CNT_EN
      total++;
      if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0)
         $display("FAIL perf_reset: got %0d/%0d want 0/0", retired_cnt, stall_cnt);
      else passed++;
`endif
   endtask

   task automatic test_timeout();
      logic [14:0] exp [7];
      exp = '{O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH_WAIT,
              O_TRAP, O_TRAP};
      imem_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #2;
         total++;
         if (obs !== exp[i]) $display("FAIL timeout_cyc%0d: got %b want %b", i, obs, exp[i]);
         else passed++;
         tick();
      end
`ifdef SEQ_PERF_CNT_EN
      total++;
      if (stall_cnt !== 32'd5) $display("FAIL stall_at_trap: got %0d want 5", stall_cnt);
      else passed++;
`endif
      reset = 1'b1;
      #2;
      total++;
      if (obs !== 15'd0) $display("FAIL trap_reset_hold: got %b want %b", obs, 15'd0);
      else passed++;
      tick();
      reset = 1'b0;
      #2;
      total++;
      if (obs !== O_FETCH_WAIT) $display("FAIL trap_cleared: got %b want %b", obs, O_FETCH_WAIT);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_store();
      test_branch();
      test_jump();
      test_fetch_limit();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
